// File: rtl/uparc_writeback_pkg.sv
// uparc writeback shared constants: widths, load types, error codes,
// FSM encodings and the latched load context.
package uparc_writeback_pkg;

  localparam int UPARC_REG_WIDTH   = 32;
  localparam int UPARC_REGNO_WIDTH = 5;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  localparam logic [1:0] WB_ERR_NONE     = 2'b00;
  localparam logic [1:0] WB_ERR_BUS      = 2'b01;
  localparam logic [1:0] WB_ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] WB_ERR_MISALIGN = 2'b11;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  typedef struct packed {
    logic [UPARC_REGNO_WIDTH-1:0] rd;
    logic [2:0]                   ltype;
    logic [1:0]                   addr_lo;
  } load_ctx_t;

  function automatic logic misaligned(
    input logic [2:0] ltype,
    input logic [1:0] addr_lo
  );
    return ((ltype == LT_LW) && (addr_lo != 2'b00)) ||
           (((ltype == LT_LH) || (ltype == LT_LHU)) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/uparc_load_align.sv
// uparc load aligner: picks the byte/halfword out of the bus word
// (little-endian) and sign- or zero-extends it to register width.
module uparc_load_align
  import uparc_writeback_pkg::*;
(
  input  logic [2:0]                 ltype,
  input  logic [1:0]                 addr_lo,
  input  logic [UPARC_REG_WIDTH-1:0] rdata,
  output logic [UPARC_REG_WIDTH-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane, then extend according to the load type.
  always_comb begin
    w_byte = rdata[{addr_lo, 3'b000} +: 8];
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    unique case (1'b1)
      (ltype == LT_LH):  data = {{16{w_half[15]}}, w_half};
      (ltype == LT_LHU): data = {16'h0000, w_half};
      (ltype == LT_LB):  data = {{24{w_byte[7]}}, w_byte};
      (ltype == LT_LBU): data = {24'h000000, w_byte};
      default:           data = rdata;
    endcase
  end

endmodule

// File: rtl/uparc_writeback.sv
// uparc writeback stage: retires results, waits for load data, drives the
// register-file write port. Optional macro: UPARC_WB_ALIGN_CHECK_EN.
module uparc_writeback
  import uparc_writeback_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         i_valid,
  input  logic [UPARC_REGNO_WIDTH-1:0] i_rd,
  input  logic [UPARC_REG_WIDTH-1:0]   i_result,
  input  logic                         i_load,
  input  logic [2:0]                   i_ltype,
  input  logic [1:0]                   i_addr_lo,
  output logic                         stall,
  input  logic                         dbus_ack,
  input  logic                         dbus_err,
  input  logic [UPARC_REG_WIDTH-1:0]   dbus_rdata,
  output logic [UPARC_REGNO_WIDTH-1:0] rd,
  output logic [UPARC_REG_WIDTH-1:0]   rd_data,
  output logic                         wb_err,
  output logic [1:0]                   wb_err_code
);

  localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

  logic [0:0]                   r_state;
  logic [7:0]                   r_cnt;
  load_ctx_t                    r_ctx;
  logic [UPARC_REGNO_WIDTH-1:0] r_rd;
  logic [UPARC_REG_WIDTH-1:0]   r_rd_data;
  logic                         r_err;
  logic [1:0]                   r_err_code;
  logic [UPARC_REG_WIDTH-1:0]   w_aligned;

  uparc_load_align u_align (
    .ltype   (r_ctx.ltype),
    .addr_lo (r_ctx.addr_lo),
    .rdata   (dbus_rdata),
    .data    (w_aligned)
  );

  // FSM, timeout counter and registered write port; rd and the error
  // pulse default to idle each cycle so a write lasts exactly one cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ctx      <= '0;
      r_rd       <= '0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
      r_err_code <= WB_ERR_NONE;
    end else begin
      r_rd       <= '0;
      r_err      <= 1'b0;
      r_err_code <= WB_ERR_NONE;
      unique case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            if (!i_load) begin
              r_rd      <= i_rd;
              r_rd_data <= i_result;
            end
`ifdef UPARC_WB_ALIGN_CHECK_EN
            else if (misaligned(i_ltype, i_addr_lo)) begin
              r_err      <= 1'b1;
              r_err_code <= WB_ERR_MISALIGN;
            end
`endif
            else begin
              r_ctx   <= '{rd: i_rd, ltype: i_ltype, addr_lo: i_addr_lo};
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dbus_ack) begin
            r_state <= S_IDLE;
            if (dbus_err) begin
              r_err      <= 1'b1;
              r_err_code <= WB_ERR_BUS;
            end else begin
              r_rd      <= r_ctx.rd;
              r_rd_data <= w_aligned;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b1;
            r_err_code <= WB_ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall       = (r_state == S_WAIT);
  assign rd          = r_rd;
  assign rd_data     = r_rd_data;
  assign wb_err      = r_err;
  assign wb_err_code = r_err_code;

endmodule

// File: tb/tb_uparc_writeback.sv
// Self-checking bench for uparc_writeback: directed steps plus randomized
// retirements checked against a behavioural load/alignment model.
module tb_uparc_writeback;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_valid;
  logic [4:0]  i_rd;
  logic [31:0] i_result;
  logic        i_load;
  logic [2:0]  i_ltype;
  logic [1:0]  i_addr_lo;
  logic        stall;
  logic        dbus_ack;
  logic        dbus_err;
  logic [31:0] dbus_rdata;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic        wb_err;
  logic [1:0]  wb_err_code;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_data = 32'h0;

  uparc_writeback #(.LOAD_TIMEOUT(TO)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_valid     (i_valid),
    .i_rd        (i_rd),
    .i_result    (i_result),
    .i_load      (i_load),
    .i_ltype     (i_ltype),
    .i_addr_lo   (i_addr_lo),
    .stall       (stall),
    .dbus_ack    (dbus_ack),
    .dbus_err    (dbus_err),
    .dbus_rdata  (dbus_rdata),
    .rd          (rd),
    .rd_data     (rd_data),
    .wb_err      (wb_err),
    .wb_err_code (wb_err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(input int lt, input int a,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (lt)
      1: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      2: return h;
      3: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      4: return b;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] erd,
                         input logic [31:0] edata, input logic eerr,
                         input logic [1:0] ecode, input logic estall);
    chk({tag, ".rd"}, 32'(rd), 32'(erd));
    chk({tag, ".rd_data"}, rd_data, edata);
    chk({tag, ".wb_err"}, 32'(wb_err), 32'(eerr));
    chk({tag, ".code"}, 32'(wb_err_code), 32'(ecode));
    chk({tag, ".stall"}, 32'(stall), 32'(estall));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nonload(input logic [4:0] r, input logic [31:0] res);
    i_valid   = 1'b1;
    i_load    = 1'b0;
    i_rd      = r;
    i_result  = res;
    i_ltype   = 3'($urandom_range(0, 4));
    i_addr_lo = 2'($urandom);
    step();
    i_valid  = 1'b0;
    exp_data = res;
    chk_out("nonload", r, exp_data, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic load(input logic [4:0] r, input int lt, input int a,
                      input logic [31:0] w, input int dly, input logic err);
    i_valid   = 1'b1;
    i_load    = 1'b1;
    i_rd      = r;
    i_ltype   = 3'(lt);
    i_addr_lo = 2'(a);
    step();
    chk("load.accept.stall", 32'(stall), 32'd1);
    chk("load.accept.rd", 32'(rd), 32'd0);
    i_valid  = 1'($urandom);
    i_load   = 1'b0;
    i_rd     = 5'($urandom);
    i_result = $urandom;
    for (int k = 0; k < dly; k++) begin
      dbus_ack   = 1'b0;
      dbus_err   = 1'($urandom);
      dbus_rdata = $urandom;
      step();
      chk("load.wait.stall", 32'(stall), 32'd1);
      chk("load.wait.rd", 32'(rd), 32'd0);
    end
    dbus_ack   = 1'b1;
    dbus_err   = err;
    dbus_rdata = w;
    step();
    dbus_ack = 1'b0;
    dbus_err = 1'b0;
    i_valid  = 1'b0;
    if (!err) exp_data = ref_load(lt, a, w);
    chk_out(err ? "load.buserr" : "load.done", err ? 5'd0 : r, exp_data,
            err, err ? 2'b01 : 2'b00, 1'b0);
  endtask

  initial begin
    nrst       = 1'b0;
    i_valid    = 1'b0;
    i_rd       = 5'd0;
    i_result   = 32'h0;
    i_load     = 1'b0;
    i_ltype    = 3'd0;
    i_addr_lo  = 2'd0;
    dbus_ack   = 1'b0;
    dbus_err   = 1'b0;
    dbus_rdata = 32'h0;

    #12;
    chk_out("reset", 5'd0, 32'h0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    step();
    chk_out("idle", 5'd0, 32'h0, 1'b0, 2'b00, 1'b0);

    nonload(5'd5, 32'hDEADBEEF);
    step();
    chk_out("nonload.after", 5'd0, 32'hDEADBEEF, 1'b0, 2'b00, 1'b0);

    load(5'd7, 3, 2, 32'h1280FF34, 3, 1'b0);
    chk("lb.const", rd_data, 32'hFFFFFF80);
    nonload(5'd9, 32'h11111111);

    load(5'd3, 2, 2, 32'h80017FFF, 0, 1'b0);
    chk("lhu.const", rd_data, 32'h00008001);
    load(5'd4, 0, 0, 32'h80017FFF, 1, 1'b0);
    chk("lw.const", rd_data, 32'h80017FFF);

    for (int k = 0; k < 3; k++) nonload(5'(10 + k), $urandom);

    load(5'd6, 0, 0, 32'hCAFEF00D, 1, 1'b1);
    load(5'd0, 4, 1, 32'h0000AB00, 2, 1'b0);
    chk("rd0.load.rd", 32'(rd), 32'd0);

    i_valid   = 1'b1;
    i_load    = 1'b1;
    i_rd      = 5'd12;
    i_ltype   = 3'd0;
    i_addr_lo = 2'd0;
    step();
    i_valid = 1'b0;
    i_load  = 1'b0;
    chk("timeout.wait1.stall", 32'(stall), 32'd1);
    for (int k = 0; k < TO - 1; k++) begin
      step();
      chk("timeout.wait.stall", 32'(stall), 32'd1);
      chk("timeout.wait.err", 32'(wb_err), 32'd0);
    end
    step();
    chk_out("timeout", 5'd0, exp_data, 1'b1, 2'b10, 1'b0);
    dbus_ack   = 1'b1;
    dbus_rdata = $urandom;
    step();
    dbus_ack = 1'b0;
    chk_out("lateack", 5'd0, exp_data, 1'b0, 2'b00, 1'b0);

`ifdef UPARC_WB_ALIGN_CHECK_EN
    i_valid   = 1'b1;
    i_load    = 1'b1;
    i_rd      = 5'd8;
    i_ltype   = 3'd0;
    i_addr_lo = 2'd1;
    step();
    i_valid = 1'b0;
    i_load  = 1'b0;
    chk_out("misalign", 5'd0, exp_data, 1'b1, 2'b11, 1'b0);
    step();
    chk_out("misalign.after", 5'd0, exp_data, 1'b0, 2'b00, 1'b0);
`else
    load(5'd8, 0, 1, 32'hA5A51234, 0, 1'b0);
    chk("lw.unaligned.const", rd_data, 32'hA5A51234);
`endif

    for (int n = 0; n < 40; n++) begin
      int lt;
      int a;
      lt = $urandom_range(0, 4);
      a  = $urandom_range(0, 3);
`ifdef UPARC_WB_ALIGN_CHECK_EN
      if (lt == 0) a = 0;
      if (lt == 1 || lt == 2) a = a & 2;
`endif
      if ($urandom_range(0, 2) == 0)
        nonload(5'($urandom), $urandom);
      else
        load(5'($urandom), lt, a, $urandom, $urandom_range(0, TO - 1),
             ($urandom_range(0, 5) == 0));
    end

    i_valid   = 1'b1;
    i_load    = 1'b1;
    i_rd      = 5'd15;
    i_ltype   = 3'd0;
    i_addr_lo = 2'd0;
    step();
    i_valid = 1'b0;
    i_load  = 1'b0;
    step();
    #2;
    nrst = 1'b0;
    #1;
    exp_data = 32'h0;
    chk_out("midwait.reset", 5'd0, exp_data, 1'b0, 2'b00, 1'b0);
    dbus_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nrst     = 1'b1;
    dbus_ack = 1'b0;
    step();
    chk_out("midwait.after", 5'd0, exp_data, 1'b0, 2'b00, 1'b0);
    nonload(5'd21, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
